// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, IR field positions and sequencer state encoding.
// The datapath ALU imports the same opcode constants so both sides agree on encodings.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MULL = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // Three-register ALU instructions occupy one contiguous opcode range.
    localparam logic [4:0] OP_ALU_FIRST = OP_ADD;
    localparam logic [4:0] OP_ALU_LAST  = OP_MULL;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_T0    = 3'd1,
        S_T1    = 3'd2,
        S_T2    = 3'd3,
        S_T3    = 3'd4,
        S_T4    = 3'd5,
        S_T5    = 3'd6,
        S_HALT  = 3'd7
    } seq_state_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-NUM_REGS one-hot decoder with enable; all zeros when disabled.
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          sel,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign onehot[gi] = en & (sel == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetches via PC/MAR/MDR/IR and executes
// three-register ALU instructions, one datapath transfer per clock.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int         NUM_REGS = 16,
    parameter logic [4:0] HALT_OP  = OP_HALT
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic [31:0]         IR,
    input  logic                Stop,
    output logic                PCout,
    output logic                IncPC,
    output logic                Zin,
    output logic                Zlowout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Read,
    output logic                Yin,
    output logic                aluin,
    output logic [4:0]          aluControl,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                Run
);

    seq_state_t state_q, state_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       alu_op;
    logic       halt_op;

    logic       rout_en;
    logic [3:0] rout_sel;
    logic       rin_en;

    // Low IR bits carry immediates for other instruction classes.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[IR_RC_LSB-1:0];

    assign opcode  = IR[IR_OP_MSB:IR_OP_LSB];
    assign ra      = IR[IR_RA_MSB:IR_RA_LSB];
    assign rb      = IR[IR_RB_MSB:IR_RB_LSB];
    assign rc      = IR[IR_RC_MSB:IR_RC_LSB];
    assign alu_op  = is_alu_op(opcode);
    assign halt_op = (opcode == HALT_OP);

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCout      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        PCin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Read       = 1'b0;
        Yin        = 1'b0;
        aluin      = 1'b0;
        aluControl = 5'd0;
        rout_en    = 1'b0;
        rout_sel   = rb;
        rin_en     = 1'b0;
        Run        = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_T0;
            end
            S_T0: begin
                Run     = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                Run     = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                Run = 1'b1;
                if (alu_op) begin
                    // First operand is parked in Y so Ra=Rb=Rc is hazard-free.
                    rout_en  = 1'b1;
                    rout_sel = rb;
                    Yin      = 1'b1;
                    state_d  = S_T4;
                end else if (halt_op) begin
                    state_d = S_HALT;
                end else begin
                    state_d = Stop ? S_HALT : S_T0;
                end
            end
            S_T4: begin
                Run        = 1'b1;
                rout_en    = 1'b1;
                rout_sel   = rc;
                aluin      = 1'b1;
                Zin        = 1'b1;
                aluControl = opcode;
                state_d    = S_T5;
            end
            S_T5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                rin_en  = 1'b1;
                state_d = Stop ? S_HALT : S_T0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    reg_select_decoder #(
        .NUM_REGS (NUM_REGS)
    ) u_rout_dec (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (Rout)
    );

    reg_select_decoder #(
        .NUM_REGS (NUM_REGS)
    ) u_rin_dec (
        .sel    (ra),
        .en     (rin_en),
        .onehot (Rin)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: the driver queues the hand-computed output vector for each
// cycle, and a negedge monitor pops and compares against the live DUT outputs.
module tb_control_sequencer;

    logic        Clock;
    logic        clear;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout, IncPC, Zin, Zlowout, PCin, MARin, MDRin, MDRout, IRin, Read, Yin, aluin;
    logic [4:0]  aluControl;
    logic [15:0] Rout, Rin;
    logic        Run;

    control_sequencer #(
        .NUM_REGS (16),
        .HALT_OP  (5'b11010)
    ) dut (
        .Clock      (Clock),
        .clear      (clear),
        .IR         (IR),
        .Stop       (Stop),
        .PCout      (PCout),
        .IncPC      (IncPC),
        .Zin        (Zin),
        .Zlowout    (Zlowout),
        .PCin       (PCin),
        .MARin      (MARin),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .IRin       (IRin),
        .Read       (Read),
        .Yin        (Yin),
        .aluin      (aluin),
        .aluControl (aluControl),
        .Rout       (Rout),
        .Rin        (Rin),
        .Run        (Run)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Strobe order: PCout IncPC Zin Zlowout PCin MARin MDRin MDRout IRin Read Yin aluin
    localparam logic [11:0] S_NONE = 12'b0000_0000_0000;
    localparam logic [11:0] S_T0   = 12'b1110_0100_0000;
    localparam logic [11:0] S_T1   = 12'b0001_1010_0100;
    localparam logic [11:0] S_T2   = 12'b0000_0001_1000;
    localparam logic [11:0] S_T3A  = 12'b0000_0000_0010;
    localparam logic [11:0] S_T4   = 12'b0010_0000_0001;
    localparam logic [11:0] S_T5   = 12'b0001_0000_0000;

    typedef struct {
        string       nm;
        logic [49:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [49:0] act;
    assign act = {Run, PCout, IncPC, Zin, Zlowout, PCin, MARin, MDRin, MDRout, IRin,
                  Read, Yin, aluin, aluControl, Rout, Rin};

    function automatic logic [49:0] mk(input logic run, input logic [11:0] s,
                                       input logic [4:0] alu, input logic [15:0] rout,
                                       input logic [15:0] rin);
        return {run, s, alu, rout, rin};
    endfunction

    localparam logic [49:0] ZERO = 50'd0;

    task automatic push(input string nm, input logic [49:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    // Queue this cycle's expectation, then advance to just after the next edge.
    task automatic step(input string nm, input logic [49:0] v);
        push(nm, v);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input string tag);
        step({tag, "_t0"}, mk(1'b1, S_T0, 5'd0, 16'h0, 16'h0));
        step({tag, "_t1"}, mk(1'b1, S_T1, 5'd0, 16'h0, 16'h0));
        step({tag, "_t2"}, mk(1'b1, S_T2, 5'd0, 16'h0, 16'h0));
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h (Run=%b aluControl=%b Rout=%h Rin=%h)",
                         e.nm, act, e.v, Run, aluControl, Rout, Rin);
            end else begin
                $display("[TB] ok %s: outputs %h", e.nm, act);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear = 1'b0;
        Stop  = 1'b0;
        IR    = 32'h28918000;   // and R1,R2,R3
        @(posedge Clock);
        #1;
        step("reset_a", ZERO);
        step("reset_b", ZERO);
        clear = 1'b1;
        step("reset_release", ZERO);

        // and R1,R2,R3
        fetch("and");
        step("and_t3", mk(1'b1, S_T3A, 5'd0,     16'h0004, 16'h0));
        step("and_t4", mk(1'b1, S_T4,  5'b00101, 16'h0008, 16'h0));
        step("and_t5", mk(1'b1, S_T5,  5'd0,     16'h0,    16'h0002));

        // add R4,R5,R6
        IR = {5'b00011, 4'd4, 4'd5, 4'd6, 15'd0};
        fetch("add");
        step("add_t3", mk(1'b1, S_T3A, 5'd0,     16'h0020, 16'h0));
        step("add_t4", mk(1'b1, S_T4,  5'b00011, 16'h0040, 16'h0));
        step("add_t5", mk(1'b1, S_T5,  5'd0,     16'h0,    16'h0010));

        // no-op: four cycles, straight back to T0
        IR = {5'b11111, 4'd7, 4'd8, 4'd9, 15'd0};
        fetch("nop");
        step("nop_t3", mk(1'b1, S_NONE, 5'd0, 16'h0, 16'h0));

        // and again, with a Stop pulse confined to T4
        IR = 32'h28918000;
        fetch("stp4");
        step("stp4_t3", mk(1'b1, S_T3A, 5'd0, 16'h0004, 16'h0));
        Stop = 1'b1;
        step("stp4_t4", mk(1'b1, S_T4, 5'b00101, 16'h0008, 16'h0));
        Stop = 1'b0;
        step("stp4_t5", mk(1'b1, S_T5, 5'd0, 16'h0, 16'h0002));

        // add with Stop held through T5 -> HALT
        IR = {5'b00011, 4'd4, 4'd5, 4'd6, 15'd0};
        fetch("stp5");
        step("stp5_t3", mk(1'b1, S_T3A, 5'd0, 16'h0020, 16'h0));
        step("stp5_t4", mk(1'b1, S_T4, 5'b00011, 16'h0040, 16'h0));
        Stop = 1'b1;
        step("stp5_t5", mk(1'b1, S_T5, 5'd0, 16'h0, 16'h0010));
        Stop = 1'b0;
        for (int i = 0; i < 3; i++) step("stp5_halt", ZERO);
        clear = 1'b0;
        step("stp5_clear", ZERO);
        clear = 1'b1;
        step("stp5_release", ZERO);

        // no-op with Stop at its end-of-instruction edge -> HALT
        IR = {5'b11111, 27'd0};
        fetch("nops");
        Stop = 1'b1;
        step("nops_t3", mk(1'b1, S_NONE, 5'd0, 16'h0, 16'h0));
        Stop = 1'b0;
        step("nops_halt", ZERO);
        clear = 1'b0;
        step("nops_clear", ZERO);
        clear = 1'b1;
        step("nops_release", ZERO);

        // HALT_OP: halt after T3 and stay there for 20 cycles
        IR = {5'b11010, 27'd0};
        fetch("hlt");
        step("hlt_t3", mk(1'b1, S_NONE, 5'd0, 16'h0, 16'h0));
        for (int i = 0; i < 20; i++) step("hlt_hold", ZERO);
        clear = 1'b0;
        step("hlt_clear", ZERO);
        clear = 1'b1;
        step("hlt_release", ZERO);

        // and R1,R2,R3 aborted by clear in the middle of T4, between edges
        IR = 32'h28918000;
        fetch("abt");
        step("abt_t3", mk(1'b1, S_T3A, 5'd0, 16'h0004, 16'h0));
        #1;
        clear = 1'b0;
        push("abt_async", ZERO);
        @(posedge Clock);
        #1;
        step("abt_hold", ZERO);
        clear = 1'b1;
        step("abt_release", ZERO);

        // Restart goes cleanly through a fresh fetch with no stray Rin
        IR = {5'b11111, 27'd0};
        fetch("post");
        step("post_t3", mk(1'b1, S_NONE, 5'd0, 16'h0, 16'h0));
        step("post_t0", mk(1'b1, S_T0, 5'd0, 16'h0, 16'h0));

        repeat (2) @(posedge Clock);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
